// File: rtl/dma_burst_engine_if.sv
// Bus bundle for the DMA burst engine: CPU register port, read/write
// memory request channels and the external staging FIFO.
interface dma_burst_engine_if #(
    parameter int DATA_WIDTH = 32
);
    // Register read-back and interrupt
    logic                  intr;
    logic [31:0]           src_base;
    logic [31:0]           dest_base;
    logic [31:0]           tail_ptr;
    logic [31:0]           head_ptr;
    logic [31:0]           dma_size;
    logic [31:0]           ctrl_stat;
    // CPU register write port
    logic [31:0]           reg_wr_data;
    logic [5:0]            reg_wr_en;
    // Read channel
    logic [31:0]           rd_req_addr;
    logic [7:0]            rd_req_len;
    logic                  rd_req_valid;
    logic                  rd_req_ready;
    logic [DATA_WIDTH-1:0] rd_rdata;
    logic                  rd_last;
    logic                  rd_valid;
    logic                  rd_ready;
    // Write channel
    logic [31:0]           wr_req_addr;
    logic [7:0]            wr_req_len;
    logic                  wr_req_valid;
    logic                  wr_req_ready;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_valid;
    logic                  wr_ready;
    logic                  wr_last;
    // External FIFO
    logic                  fifo_rden;
    logic [DATA_WIDTH-1:0] fifo_wdata;
    logic                  fifo_wen;
    logic [DATA_WIDTH-1:0] fifo_rdata;
    logic                  fifo_is_empty;
    logic                  fifo_is_full;

    // Engine side
    modport master (
        output intr, src_base, dest_base, tail_ptr, head_ptr, dma_size, ctrl_stat,
        input  reg_wr_data, reg_wr_en,
        output rd_req_addr, rd_req_len, rd_req_valid, rd_ready,
        input  rd_req_ready, rd_rdata, rd_last, rd_valid,
        output wr_req_addr, wr_req_len, wr_req_valid, wr_data, wr_valid, wr_last,
        input  wr_req_ready, wr_ready,
        output fifo_rden, fifo_wdata, fifo_wen,
        input  fifo_rdata, fifo_is_empty, fifo_is_full
    );

    // CPU / memory / FIFO side
    modport slave (
        input  intr, src_base, dest_base, tail_ptr, head_ptr, dma_size, ctrl_stat,
        output reg_wr_data, reg_wr_en,
        input  rd_req_addr, rd_req_len, rd_req_valid, rd_ready,
        output rd_req_ready, rd_rdata, rd_last, rd_valid,
        input  wr_req_addr, wr_req_len, wr_req_valid, wr_data, wr_valid, wr_last,
        output wr_req_ready, wr_ready,
        input  fifo_rden, fifo_wdata, fifo_wen,
        output fifo_rdata, fifo_is_empty, fifo_is_full
    );
endinterface

// File: rtl/dma_burst_engine.sv
// DMA burst engine: copies one ring sub-buffer (dma_size bytes at
// tail_ptr) from src_base to dest_base in bursts of up to BURST_WORDS
// words, staging data through an external FIFO, then advances tail_ptr
// and raises the interrupt.
module dma_burst_engine #(
    parameter int DATA_WIDTH  = 32,
    parameter int BURST_WORDS = 8,
    parameter int RING_BYTES  = 4096
) (
    input  logic                   clk,
    input  logic                   rst,
    dma_burst_engine_if.master     bus
);
    localparam int BPW      = DATA_WIDTH / 8;
    localparam int LOG2_BPW = $clog2(BPW);

    typedef enum logic [4:0] {
        S_IDLE   = 5'b00001,
        S_RD_REQ = 5'b00010,
        S_RD     = 5'b00100,
        S_WR_REQ = 5'b01000,
        S_WR     = 5'b10000
    } state_t;

    state_t      r_state;
    logic [31:0] r_offset;
    logic [4:0]  r_beat;
    logic        r_wr_last;

    logic [31:0] r_src_base;
    logic [31:0] r_dest_base;
    logic [31:0] r_tail_ptr;
    logic [31:0] r_head_ptr;
    logic [31:0] r_dma_size;
    logic [3:0]  r_ctrl;
    logic        r_intr;

    logic [31:0] w_size_aligned;
    logic [31:0] w_remaining;
    logic [31:0] w_words;
    logic [4:0]  w_burst_words;
    logic [7:0]  w_burst_len;
    logic [31:0] w_next_offset;
    logic        w_burst_end;
    logic        w_done;
    logic        w_start;
    logic        w_unused;

    // FIFO status is not needed: the FIFO is sized to hold a full burst.
    assign w_unused = &{1'b0, bus.fifo_is_empty, bus.fifo_is_full};

    // Size of the current burst and the offset that follows it.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_size_aligned = r_dma_size & ~32'(BPW - 1);
        w_remaining    = w_size_aligned - r_offset;
        w_words        = w_remaining >> LOG2_BPW;
        w_burst_words  = 5'(BURST_WORDS);
        if (w_words < 32'(BURST_WORDS)) begin
            w_burst_words = w_words[4:0];
        end
        w_burst_len    = {3'b000, w_burst_words} - 8'd1;
        w_next_offset  = r_offset + (32'(w_burst_words) << LOG2_BPW);
    end

    assign w_start     = r_ctrl[0] && (r_head_ptr != r_tail_ptr) && (w_size_aligned >= 32'(BPW));
    assign w_burst_end = (r_state == S_WR) && bus.wr_ready && r_wr_last;
    assign w_done      = w_burst_end && (w_next_offset == w_size_aligned);

    // Transfer sequencer: state, sub-buffer offset, write beat counter and wr_last flag.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_offset  <= '0;
            r_beat    <= '0;
            r_wr_last <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_offset <= '0;
                    if (w_start) begin
                        r_state <= S_RD_REQ;
                    end
                end
                S_RD_REQ: begin
                    if (bus.rd_req_ready) begin
                        r_state <= S_RD;
                    end
                end
                S_RD: begin
                    // A short read (early rd_last) still ends the burst.
                    if (bus.rd_valid && bus.rd_last) begin
                        r_state <= S_WR_REQ;
                    end
                end
                S_WR_REQ: begin
                    if (bus.wr_req_ready) begin
                        r_state   <= S_WR;
                        r_beat    <= '0;
                        r_wr_last <= (w_burst_len == 8'd0);
                    end
                end
                S_WR: begin
                    if (bus.wr_ready) begin
                        if (r_wr_last) begin
                            r_offset  <= w_next_offset;
                            r_beat    <= '0;
                            r_wr_last <= 1'b0;
                            r_state   <= (w_next_offset == w_size_aligned) ? S_IDLE : S_RD_REQ;
                        end else begin
                            r_beat    <= r_beat + 5'd1;
                            r_wr_last <= ({3'b000, r_beat + 5'd1} == w_burst_len);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // CPU register file; completion updates are placed last so they win a same-cycle CPU write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_src_base  <= '0;
            r_dest_base <= '0;
            r_tail_ptr  <= '0;
            r_head_ptr  <= '0;
            r_dma_size  <= '0;
            r_ctrl      <= '0;
            r_intr      <= 1'b0;
        end else begin
            // Address/size registers are frozen while a transfer is in flight.
            if (r_state == S_IDLE) begin
                if (bus.reg_wr_en[0]) r_src_base  <= bus.reg_wr_data;
                if (bus.reg_wr_en[1]) r_dest_base <= bus.reg_wr_data;
                if (bus.reg_wr_en[2]) r_tail_ptr  <= bus.reg_wr_data;
                if (bus.reg_wr_en[3]) r_head_ptr  <= bus.reg_wr_data;
                if (bus.reg_wr_en[4]) r_dma_size  <= bus.reg_wr_data;
            end
            // Control bits are writable any time; bit 31 is write-1-to-clear.
            if (bus.reg_wr_en[5]) begin
                r_ctrl <= bus.reg_wr_data[3:0];
                if (bus.reg_wr_data[31]) begin
                    r_intr <= 1'b0;
                end
            end
            if (w_done) begin
                r_tail_ptr <= (r_tail_ptr + w_size_aligned) & 32'(RING_BYTES - 1);
                r_intr     <= 1'b1;
            end
        end
    end

    // Handshake valids decode straight from the one-hot state flops.
    assign bus.rd_req_valid = (r_state == S_RD_REQ);
    assign bus.rd_ready     = (r_state == S_RD);
    assign bus.wr_req_valid = (r_state == S_WR_REQ);
    assign bus.wr_valid     = (r_state == S_WR);
    assign bus.wr_last      = r_wr_last;

    assign bus.rd_req_addr  = r_src_base + r_tail_ptr + r_offset;
    assign bus.wr_req_addr  = r_dest_base + r_tail_ptr + r_offset;
    assign bus.rd_req_len   = w_burst_len;
    assign bus.wr_req_len   = w_burst_len;

    // Read data streams straight into the FIFO; the FIFO output feeds the write channel.
    assign bus.fifo_wen     = (r_state == S_RD) && bus.rd_valid;
    assign bus.fifo_wdata   = bus.rd_rdata;
    // Prefetch the first word on request acceptance, then one word per accepted non-last beat.
    assign bus.fifo_rden    = ((r_state == S_WR_REQ) && bus.wr_req_ready) ||
                              ((r_state == S_WR) && bus.wr_ready && !r_wr_last);
    assign bus.wr_data      = bus.fifo_rdata;

    assign bus.intr         = r_intr;
    assign bus.src_base     = r_src_base;
    assign bus.dest_base    = r_dest_base;
    assign bus.tail_ptr     = r_tail_ptr;
    assign bus.head_ptr     = r_head_ptr;
    assign bus.dma_size     = r_dma_size;
    assign bus.ctrl_stat    = {r_intr, r_state, 22'd0, r_ctrl};
endmodule

// File: tb/tb_dma_burst_engine.sv
// Directed bench for dma_burst_engine: behavioural read/write memory
// responders and FIFO, with hand-computed expected addresses, lengths,
// data words and register values.
module tb_dma_burst_engine;
    logic clk;
    logic rst;

    dma_burst_engine_if #(.DATA_WIDTH(32)) bus ();

    dma_burst_engine #(
        .DATA_WIDTH (32),
        .BURST_WORDS(8),
        .RING_BYTES (4096)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Source/destination bases of the transfer under test (for data expectations)
    logic [31:0] cur_src  = 32'h1000;
    logic [31:0] cur_dest = 32'h2000;
    int          stall_burst = -1;

    // ---------------- FIFO model: data valid one cycle after fifo_rden ----------------
    logic [31:0] fifo_mem [0:31];
    int          fifo_wp = 0;
    int          fifo_rp = 0;
    initial begin
        bus.fifo_rdata    = '0;
        bus.fifo_is_empty = 1'b1;
        bus.fifo_is_full  = 1'b0;
        forever begin
            @(posedge clk);
            if (rst) begin
                fifo_wp = 0;
                fifo_rp = 0;
            end else begin
                if (bus.fifo_wen) begin
                    fifo_mem[fifo_wp % 32] = bus.fifo_wdata;
                    fifo_wp++;
                end
                if (bus.fifo_rden) begin
                    bus.fifo_rdata = fifo_mem[fifo_rp % 32];
                    fifo_rp++;
                end
            end
            bus.fifo_is_empty = (fifo_wp == fifo_rp);
            bus.fifo_is_full  = ((fifo_wp - fifo_rp) >= 32);
        end
    end

    // ---------------- Read responder: word data = 0xA0000000 | byte address ----------------
    int          rd_cnt = 0;
    logic [31:0] rd_addr_log [0:63];
    int          rd_len_log  [0:63];
    logic [31:0] rd_cur = '0;
    int          rd_left = 0;
    initial begin
        bus.rd_valid = 1'b0;
        bus.rd_last  = 1'b0;
        bus.rd_rdata = '0;
        forever begin
            @(negedge clk);
            bus.rd_valid = 1'b0;
            bus.rd_last  = 1'b0;
            if (rst) begin
                rd_left = 0;
            end else begin
                if (bus.rd_ready && rd_left > 0) begin
                    bus.rd_valid = 1'b1;
                    bus.rd_rdata = 32'hA000_0000 | rd_cur;
                    bus.rd_last  = (rd_left == 1);
                    rd_cur  = rd_cur + 32'd4;
                    rd_left--;
                end
                if (bus.rd_req_valid) begin
                    rd_addr_log[rd_cnt] = bus.rd_req_addr;
                    rd_len_log[rd_cnt]  = int'(bus.rd_req_len);
                    rd_cnt++;
                    rd_cur  = bus.rd_req_addr;
                    rd_left = int'(bus.rd_req_len) + 1;
                end
            end
        end
    end

    // ---------------- Write responder: checks every beat, optional 5-cycle stall ----------------
    int          wr_cnt = 0;
    logic [31:0] wr_addr_log [0:63];
    int          wr_len_log  [0:63];
    logic [31:0] wr_cur_addr = '0;
    int          wr_cur_len = 0;
    int          wr_beat = 0;
    int          wr_beats = 0;
    int          stall_left = 0;
    int          stall_seen = 0;
    int          stall_done_burst = -1;
    logic [31:0] held_data = '0;
    initial begin
        bus.wr_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (rst) begin
                bus.wr_ready = 1'b1;
                stall_left   = 0;
                wr_beat      = 0;
            end else begin
                if (bus.wr_req_valid) begin
                    wr_addr_log[wr_cnt] = bus.wr_req_addr;
                    wr_len_log[wr_cnt]  = int'(bus.wr_req_len);
                    wr_cur_addr = bus.wr_req_addr;
                    wr_cur_len  = int'(bus.wr_req_len);
                    wr_cnt++;
                    wr_beat = 0;
                end
                if (bus.wr_valid) begin
                    if (bus.wr_ready) begin
                        check("wdata", bus.wr_data,
                              32'hA000_0000 | (cur_src + (wr_cur_addr - cur_dest) + 32'(4 * wr_beat)));
                        check("wlast", 32'(bus.wr_last), 32'(wr_beat == wr_cur_len));
                        wr_beat++;
                        wr_beats++;
                    end else begin
                        if (stall_seen == 0) held_data = bus.wr_data;
                        else check("stall_data", bus.wr_data, held_data);
                        check("stall_rden", 32'(bus.fifo_rden), 32'd0);
                        stall_seen++;
                    end
                end else if (stall_left > 0) begin
                    check("stall_valid", 32'(bus.wr_valid), 32'd1);
                end
                if (stall_left > 0) begin
                    stall_left--;
                    if (stall_left == 0) bus.wr_ready = 1'b1;
                end else if (bus.wr_valid && wr_cnt == stall_burst &&
                             stall_done_burst != stall_burst && wr_beat == 3) begin
                    bus.wr_ready     = 1'b0;
                    stall_left       = 5;
                    stall_seen       = 0;
                    stall_done_burst = stall_burst;
                end
            end
        end
    end

    // ---------------- CPU helpers ----------------
    task automatic reg_write(input int idx, input logic [31:0] data);
        bus.reg_wr_en   = 6'(1 << idx);
        bus.reg_wr_data = data;
        @(negedge clk);
        bus.reg_wr_en   = '0;
    endtask

    task automatic wait_intr(input int budget, input string tag);
        int n = 0;
        while (!bus.intr && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(bus.intr), 32'd1);
    endtask

    int  rb;
    int  wb;
    int  wbeats0;
    bit  found;

    initial begin
        bus.reg_wr_en    = '0;
        bus.reg_wr_data  = '0;
        bus.rd_req_ready = 1'b1;
        bus.wr_req_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_intr",      32'(bus.intr), 32'd0);
        check("rst_rdreqv",    32'(bus.rd_req_valid), 32'd0);
        check("rst_rdready",   32'(bus.rd_ready), 32'd0);
        check("rst_wrreqv",    32'(bus.wr_req_valid), 32'd0);
        check("rst_wrvalid",   32'(bus.wr_valid), 32'd0);
        check("rst_wrlast",    32'(bus.wr_last), 32'd0);
        check("rst_fifo",      32'({bus.fifo_wen, bus.fifo_rden}), 32'd0);
        check("rst_dma_size",  bus.dma_size, 32'd0);
        check("rst_tail",      bus.tail_ptr, 32'd0);
        check("rst_ctrl_stat", bus.ctrl_stat, 32'h0400_0000);

        // 64 bytes in two 8-word bursts
        reg_write(0, 32'h1000);
        reg_write(1, 32'h2000);
        reg_write(4, 32'd64);
        reg_write(3, 32'd64);
        reg_write(5, 32'd1);
        wait_intr(300, "t1_intr");
        check("t1_rd_cnt",   32'(rd_cnt), 32'd2);
        check("t1_rd_addr0", rd_addr_log[0], 32'h1000);
        check("t1_rd_len0",  32'(rd_len_log[0]), 32'd7);
        check("t1_rd_addr1", rd_addr_log[1], 32'h1020);
        check("t1_wr_addr0", wr_addr_log[0], 32'h2000);
        check("t1_wr_addr1", wr_addr_log[1], 32'h2020);
        check("t1_wr_len1",  32'(wr_len_log[1]), 32'd7);
        check("t1_beats",    32'(wr_beats), 32'd16);
        check("t1_tail",     bus.tail_ptr, 32'd64);
        check("t1_ctrl",     bus.ctrl_stat, 32'h8400_0001);

        // 40 bytes: bursts of 8 and 2 words; enable cleared and src written
        // mid-transfer; W1C on the completion edge loses to the done pulse
        reg_write(5, 32'd0);
        reg_write(2, 32'd0);
        reg_write(3, 32'h100);
        reg_write(4, 32'd40);
        rb = rd_cnt;
        wb = wr_cnt;
        wbeats0 = wr_beats;
        reg_write(5, 32'd1);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (bus.wr_req_valid) found = 1'b1;
        end
        check("t3_wrreq_seen", 32'(found), 32'd1);
        reg_write(5, 32'd0);
        reg_write(0, 32'hDEAD_0000);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (bus.wr_valid && bus.wr_last && wr_cnt == wb + 2) begin
                reg_write(5, 32'h8000_0000);
                found = 1'b1;
            end
        end
        check("t3_done_seen", 32'(found), 32'd1);
        check("t3_intr_wins", 32'(bus.intr), 32'd1);
        repeat (20) @(negedge clk);
        check("t3_rd_cnt",   32'(rd_cnt - rb), 32'd2);
        check("t3_rd_len0",  32'(rd_len_log[rb]), 32'd7);
        check("t3_rd_addr1", rd_addr_log[rb + 1], 32'h1020);
        check("t3_rd_len1",  32'(rd_len_log[rb + 1]), 32'd1);
        check("t3_wr_addr1", wr_addr_log[wb + 1], 32'h2020);
        check("t3_wr_len1",  32'(wr_len_log[wb + 1]), 32'd1);
        check("t3_beats",    32'(wr_beats - wbeats0), 32'd10);
        check("t3_src_kept", bus.src_base, 32'h1000);
        check("t3_tail",     bus.tail_ptr, 32'd40);
        check("t3_ctrl",     bus.ctrl_stat, 32'h8400_0000);

        // W1C of intr with enable kept; head==tail keeps the engine idle
        reg_write(3, 32'd40);
        reg_write(5, 32'h8000_0001);
        check("t2_intr_clr", 32'(bus.intr), 32'd0);
        check("t2_ctrl",     bus.ctrl_stat, 32'h0400_0001);
        rb = rd_cnt;
        repeat (10) @(negedge clk);
        check("t2_idle", 32'(rd_cnt - rb), 32'd0);

        // Ring wrap from tail 4032, with a 5-cycle wr_ready stall in the first burst
        reg_write(5, 32'd0);
        reg_write(2, 32'd4032);
        reg_write(3, 32'd0);
        reg_write(4, 32'd64);
        rb = rd_cnt;
        wb = wr_cnt;
        stall_burst = wr_cnt + 1;
        reg_write(5, 32'd1);
        wait_intr(400, "t4_intr");
        check("t4_rd_addr0", rd_addr_log[rb], 32'h1FC0);
        check("t4_rd_addr1", rd_addr_log[rb + 1], 32'h1FE0);
        check("t4_wr_addr0", wr_addr_log[wb], 32'h2FC0);
        check("t4_wr_addr1", wr_addr_log[wb + 1], 32'h2FE0);
        check("t4_stall_cycles", 32'(stall_seen), 32'd5);
        check("t4_tail",     bus.tail_ptr, 32'd0);
        check("t4_ctrl",     bus.ctrl_stat, 32'h8400_0001);
        repeat (10) @(negedge clk);
        check("t4_idle", 32'(rd_cnt - rb), 32'd2);

        // Reset in the middle of a write burst
        reg_write(3, 32'd64);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (bus.wr_valid && wr_beat == 3) found = 1'b1;
        end
        check("t5_beat3_seen", 32'(found), 32'd1);
        #2 rst = 1'b1;
        @(negedge clk);
        check("t5_valids", 32'({bus.rd_req_valid, bus.rd_ready, bus.wr_req_valid,
                                bus.wr_valid, bus.wr_last, bus.fifo_wen, bus.fifo_rden}), 32'd0);
        check("t5_intr",  32'(bus.intr), 32'd0);
        check("t5_ctrl",  bus.ctrl_stat, 32'h0400_0000);
        check("t5_tail",  bus.tail_ptr, 32'd0);
        rst = 1'b0;
        rb = rd_cnt;
        wb = wr_cnt;
        wbeats0 = wr_beats;
        repeat (20) @(negedge clk);
        check("t5_no_hs", 32'((rd_cnt - rb) + (wr_cnt - wb) + (wr_beats - wbeats0)), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dma_burst_engine.md
DMA_BURST_ENGINE -- requirements
Module: dma_burst_engine

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32; memory/FIFO data width in bits, 32 or 64; BPW = DATA_WIDTH/8 bytes per word.
REQ-002 SHALL have parameter BURST_WORDS, default 8; maximum words per burst, power of two, 1..16.
REQ-003 SHALL have parameter RING_BYTES, default 4096; ring-buffer size in bytes, power of two; tail_ptr wraps modulo RING_BYTES.
REQ-004 One clock; reset is asynchronous and active-high. Ports: clk input 1, rising-edge clock; rst input 1, asynchronous active-high reset.
REQ-005 Ports intr (out 1, interrupt = ctrl_stat[31]); src_base, dest_base, tail_ptr, head_ptr, dma_size, ctrl_stat (each out 32, register read-back).
REQ-006 Ports reg_wr_data (in 32), reg_wr_en (in 6, one-hot; bits 0..5 select src_base, dest_base, tail_ptr, head_ptr, dma_size, ctrl_stat).
REQ-007 Read-side ports: rd_req_addr (out 32), rd_req_len (out 8, words-1), rd_req_valid (out 1), rd_req_ready (in 1), rd_rdata (in DATA_WIDTH), rd_last (in 1), rd_valid (in 1), rd_ready (out 1).
REQ-008 Write-side ports: wr_req_addr (out 32), wr_req_len (out 8), wr_req_valid (out 1), wr_req_ready (in 1), wr_data (out DATA_WIDTH), wr_valid (out 1), wr_ready (in 1), wr_last (out 1).
REQ-009 FIFO ports: fifo_rden (out 1), fifo_wdata (out DATA_WIDTH), fifo_wen (out 1), fifo_rdata (in DATA_WIDTH), fifo_is_empty (in 1), fifo_is_full (in 1); external FIFO depth >= BURST_WORDS.

Function
REQ-010 States SHALL be IDLE, RD_REQ, RD, WR_REQ, WR, one-hot codes 00001, 00010, 00100, 01000, 10000.
REQ-011 IDLE->RD_REQ when ctrl_stat[0]=1, head_ptr!=tail_ptr, dma_size>=BPW; otherwise stay IDLE.
REQ-012 Burst words W = min(BURST_WORDS, (dma_size-offset)/BPW); rd_req_len = wr_req_len = W-1; dma_size low log2(BPW) bits ignored.
REQ-013 rd_req_addr = src_base+tail_ptr+offset; wr_req_addr = dest_base+tail_ptr+offset; offset resets to 0 at each sub-buffer start.
REQ-014 RD_REQ: rd_req_valid=1; RD_REQ->RD on rd_req_ready. RD: rd_ready=1; fifo_wen = rd_valid, fifo_wdata = rd_rdata; RD->WR_REQ on rd_valid&rd_last.
REQ-015 WR_REQ: wr_req_valid=1; fifo_rden=1 on cycle of wr_req_ready (prefetch); WR_REQ->WR on wr_req_ready.
REQ-016 WR: wr_valid=1, wr_data=fifo_rdata (valid one cycle after fifo_rden); beat counter increments on wr_ready; wr_last=1 when counter==W-1; fifo_rden on wr_ready&~wr_last.
REQ-017 On wr_ready&wr_last: offset += W*BPW; if new offset==dma_size -> sub-buffer done, state IDLE; else -> RD_REQ.
REQ-018 Sub-buffer done SHALL, same edge: tail_ptr <= (tail_ptr+dma_size) mod RING_BYTES; ctrl_stat[31] <= 1.
REQ-019 Engine tail_ptr/ctrl_stat[31] update SHALL win over a same-cycle CPU write to those fields; CPU writes to other registers in that cycle SHALL still apply.
REQ-020 CPU write to ctrl_stat: bits[3:0] stored; bit31 write-1-to-clear; other bits ignored.
REQ-021 ctrl_stat read-back = {intr, state[4:0], 22'b0, stored[3:0]}.
REQ-022 Clearing ctrl_stat[0] mid-transfer SHALL NOT abort; current sub-buffer completes, then IDLE holds.
REQ-023 Registers other than via REQ-018/020 SHALL be written only while state==IDLE; writes in other states SHALL be dropped.
REQ-024 rd_last arriving before W beats SHALL end the burst (FIFO holds fewer words; no error flag); rd_valid outside RD ignored.

Reset
REQ-025 rst=1 SHALL asynchronously force state IDLE, offset 0, beat counter 0, all registers 0 except dma_size; dma_size reset = 0.
REQ-026 During/after reset: rd_req_valid, rd_ready, wr_req_valid, wr_valid, wr_last, fifo_wen, fifo_rden, intr = 0; reset mid-burst abandons transfer with no further handshakes.

Verification
REQ-027 DATA_WIDTH=32, BURST_WORDS=8: src=0x1000, dest=0x2000, dma_size=64, head=64, enable -> two 8-word read/write bursts at 0x1000/0x2000, 0x1020/0x2020; tail_ptr=64, intr=1.
REQ-028 dma_size=40 -> bursts of 8 then 2 words (len 7, 1); second addresses src+0x20; tail_ptr=40.
REQ-029 RING_BYTES=4096, tail=4032, head=0, dma_size=64 -> transfer from src+4032; tail_ptr wraps to 0; engine IDLE since head==tail.
REQ-030 Write ctrl_stat=0x80000001 with intr=1 -> intr=0, enable stays 1; same-cycle done pulse -> intr remains 1.
REQ-031 Assert rst during WR beat 3 -> next cycle all valids 0, state IDLE, tail_ptr=0.
REQ-032 wr_ready held low 5 cycles mid-burst -> wr_data/wr_valid stable, no fifo_rden until wr_ready returns.
